// File: rtl/commit_trace_packer.sv
// commit_trace_packer: samples CPU commit signals each enabled cycle, classifies
// them into trace records, buffers them in a FWFT FIFO and streams them out over
// valid/ready. Appends a STATS record after HALT, or a TIMEOUT record when the
// sampled-cycle budget runs out.
module commit_trace_packer #(
  parameter int DEPTH      = 8,
  parameter bit EMIT_NOP   = 1'b1,
  parameter int MAX_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic        reg_write,
  input  logic [3:0]  write_reg,
  input  logic [15:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_data,
  input  logic        halt,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [2:0]  rec_type,
  output logic [15:0] rec_inum,
  output logic [15:0] rec_pc,
  output logic [15:0] rec_a,
  output logic [15:0] rec_b,
  output logic [3:0]  rec_reg,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [31:0]   MAX_CYC_C = 32'(MAX_CYCLES);

  localparam logic [2:0] T_LOAD    = 3'd0;
  localparam logic [2:0] T_REG     = 3'd1;
  localparam logic [2:0] T_STORE   = 3'd2;
  localparam logic [2:0] T_NOP     = 3'd3;
  localparam logic [2:0] T_HALT    = 3'd4;
  localparam logic [2:0] T_STATS   = 3'd5;
  localparam logic [2:0] T_TIMEOUT = 3'd6;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_HALT_WAIT  = 2'd1,
    S_STATS_PUSH = 2'd2,
    S_DONE       = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] inum;
    logic [15:0] pc;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  rg;
  } rec_t;

  state_e          state_q, state_d;
  logic [15:0]     inum_q, inum_d;
  logic [31:0]     cycle_q, cycle_d;
  logic            timeout_q, timeout_d;
  rec_t            hold_q, hold_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_q, drop_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            done_q, done_d;
  rec_t            mem_q [DEPTH];

  rec_t            samp_rec_s;
  rec_t            push_rec_s;
  rec_t            head_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            valid_s;

  // The instruction word is carried on the port for future use only.
  logic unused_inst_s;
  assign unused_inst_s = ^inst;

  // Saturating increment for the dropped-record counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'd255) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Classify the current commit cycle: reg_write beats halt beats mem_write.
  always_comb begin
    samp_rec_s      = '0;
    samp_rec_s.inum = inum_q;
    samp_rec_s.pc   = pc;
    if (reg_write) begin
      if (mem_read) begin
        samp_rec_s.typ = T_LOAD;
        samp_rec_s.a   = write_data;
        samp_rec_s.b   = mem_addr;
        samp_rec_s.rg  = write_reg;
      end else begin
        samp_rec_s.typ = T_REG;
        samp_rec_s.a   = write_data;
        samp_rec_s.rg  = write_reg;
      end
    end else if (halt) begin
      samp_rec_s.typ = T_HALT;
    end else if (mem_write) begin
      samp_rec_s.typ = T_STORE;
      samp_rec_s.a   = mem_addr;
      samp_rec_s.b   = mem_data;
    end else begin
      samp_rec_s.typ = T_NOP;
    end
  end

  // Head-of-FIFO view; fields read zero whenever nothing is buffered.
  always_comb begin
    valid_s = (count_q != '0);
    pop_s   = valid_s && rec_ready;
    full_s  = (count_q == DEPTH_C) && !pop_s;
    if (valid_s) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
  end

  // Sequencer next state: sampling, drop accounting, halt/stats/timeout flow.
  always_comb begin
    state_d    = state_q;
    inum_d     = inum_q;
    cycle_d    = cycle_q;
    timeout_d  = timeout_q;
    hold_d     = hold_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    push_s     = 1'b0;
    push_rec_s = '0;
    case (state_q)
      S_RUN: begin
        if (en) begin
          cycle_d = cycle_q + 32'd1;
          inum_d  = inum_q + 16'd1;
          if (samp_rec_s.typ == T_HALT) begin
            // HALT is never dropped: park it until the FIFO has room.
            if (!full_s) begin
              push_s     = 1'b1;
              push_rec_s = samp_rec_s;
              state_d    = S_STATS_PUSH;
            end else begin
              hold_d  = samp_rec_s;
              state_d = S_HALT_WAIT;
            end
          end else begin
            if ((samp_rec_s.typ != T_NOP) || EMIT_NOP) begin
              if (!full_s) begin
                push_s     = 1'b1;
                push_rec_s = samp_rec_s;
              end else begin
                overflow_d = 1'b1;
                drop_d     = sat_inc8(drop_q);
              end
            end else begin
              push_s = 1'b0;
            end
            if (cycle_d == MAX_CYC_C) begin
              timeout_d = 1'b1;
              state_d   = S_STATS_PUSH;
            end else begin
              state_d = S_RUN;
            end
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_HALT_WAIT: begin
        if (!full_s) begin
          push_s     = 1'b1;
          push_rec_s = hold_q;
          state_d    = S_STATS_PUSH;
        end else begin
          state_d = S_HALT_WAIT;
        end
      end
      S_STATS_PUSH: begin
        if (!full_s) begin
          push_s          = 1'b1;
          push_rec_s.typ  = timeout_q ? T_TIMEOUT : T_STATS;
          push_rec_s.inum = inum_q;
          push_rec_s.a    = cycle_q[15:0];
          push_rec_s.b    = cycle_q[31:16];
          state_d         = S_DONE;
        end else begin
          state_d = S_STATS_PUSH;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    done_d = (state_d == S_DONE) && (count_d == '0);
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      inum_q     <= 16'd0;
      cycle_q    <= 32'd0;
      timeout_q  <= 1'b0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inum_q     <= inum_d;
      cycle_q    <= cycle_d;
      timeout_q  <= timeout_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
    end
  end

  // Record storage; contents are don't-care until the occupancy says valid.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_q[wr_ptr_q] <= push_rec_s;
    end
  end

  assign rec_valid  = valid_s;
  assign rec_type   = head_s.typ;
  assign rec_inum   = head_s.inum;
  assign rec_pc     = head_s.pc;
  assign rec_a      = head_s.a;
  assign rec_b      = head_s.b;
  assign rec_reg    = head_s.rg;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
  assign done       = done_q;

endmodule

// File: tb/tb_commit_trace_packer.sv
// Directed bench for commit_trace_packer: classification table, halt flow,
// backpressure/overflow, halt while full, mid-stream reset and timeout.
module tb_commit_trace_packer;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        en, en2;
  logic [15:0] pc, inst;
  logic        reg_write, mem_read, mem_write, halt;
  logic [3:0]  write_reg;
  logic [15:0] write_data, mem_addr, mem_data;
  logic        rdy, rdy2;

  logic        rec_valid, overflow, done;
  logic [2:0]  rec_type;
  logic [15:0] rec_inum, rec_pc, rec_a, rec_b;
  logic [3:0]  rec_reg;
  logic [7:0]  drop_count;

  logic        rec_valid2, overflow2, done2;
  logic [2:0]  rec_type2;
  logic [15:0] rec_inum2, rec_pc2, rec_a2, rec_b2;
  logic [3:0]  rec_reg2;
  logic [7:0]  drop_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  commit_trace_packer #(.DEPTH(8), .EMIT_NOP(1'b1), .MAX_CYCLES(100000)) u_dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .halt(halt),
    .rec_valid(rec_valid), .rec_ready(rdy), .rec_type(rec_type),
    .rec_inum(rec_inum), .rec_pc(rec_pc), .rec_a(rec_a), .rec_b(rec_b),
    .rec_reg(rec_reg), .overflow(overflow), .drop_count(drop_count), .done(done)
  );

  commit_trace_packer #(.DEPTH(8), .EMIT_NOP(1'b0), .MAX_CYCLES(20)) u_dut_to (
    .clk(clk), .rst(rst2), .en(en2), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .halt(halt),
    .rec_valid(rec_valid2), .rec_ready(rdy2), .rec_type(rec_type2),
    .rec_inum(rec_inum2), .rec_pc(rec_pc2), .rec_a(rec_a2), .rec_b(rec_b2),
    .rec_reg(rec_reg2), .overflow(overflow2), .drop_count(drop_count2), .done(done2)
  );

  typedef struct {
    logic        rw, mr, mw, h;
    logic [3:0]  wreg;
    logic [15:0] wdata, vpc, addr, mdata;
    logic [2:0]  et;
    logic [15:0] einum, epc, ea, eb;
    logic [3:0]  ereg;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] rec1();
    return 96'({rec_type, rec_inum, rec_pc, rec_a, rec_b, rec_reg});
  endfunction

  function automatic logic [95:0] rec2();
    return 96'({rec_type2, rec_inum2, rec_pc2, rec_a2, rec_b2, rec_reg2});
  endfunction

  function automatic logic [95:0] mk(input logic [2:0] t, input logic [15:0] n,
                                     input logic [15:0] p, input logic [15:0] a,
                                     input logic [15:0] b, input logic [3:0] r);
    return 96'({t, n, p, a, b, r});
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rw, input logic mr, input logic mw, input logic h,
                       input logic [3:0] wr, input logic [15:0] wd, input logic [15:0] p,
                       input logic [15:0] ad, input logic [15:0] md);
    reg_write = rw; mem_read = mr; mem_write = mw; halt = h;
    write_reg = wr; write_data = wd; pc = p; mem_addr = ad; mem_data = md;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
  endtask

  task automatic reset1();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int nrec;
    logic [95:0] got;

    // Classification table; noise on unused inputs checks the field mapping.
    tbl[0] = '{1'b1,1'b0,1'b0,1'b0, 4'd3, 16'h1234, 16'h0002, 16'h5555, 16'h6666,
               3'd1, 16'd0, 16'h0002, 16'h1234, 16'h0000, 4'd3};
    tbl[1] = '{1'b1,1'b1,1'b0,1'b0, 4'd5, 16'hBEEF, 16'h0004, 16'h0040, 16'h7777,
               3'd0, 16'd1, 16'h0004, 16'hBEEF, 16'h0040, 4'd5};
    tbl[2] = '{1'b0,1'b0,1'b1,1'b0, 4'd9, 16'h1111, 16'h0006, 16'h0042, 16'h00AA,
               3'd2, 16'd2, 16'h0006, 16'h0042, 16'h00AA, 4'd0};
    tbl[3] = '{1'b0,1'b0,1'b0,1'b0, 4'd0, 16'h0000, 16'h0008, 16'h0000, 16'h0000,
               3'd3, 16'd3, 16'h0008, 16'h0000, 16'h0000, 4'd0};
    tbl[4] = '{1'b0,1'b1,1'b0,1'b0, 4'd4, 16'h2222, 16'h000A, 16'h3333, 16'h4444,
               3'd3, 16'd4, 16'h000A, 16'h0000, 16'h0000, 4'd0};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b0, 4'd0, 16'h0000, 16'h000C, 16'h0000, 16'h0000,
               3'd3, 16'd5, 16'h000C, 16'h0000, 16'h0000, 4'd0};
    tbl[6] = '{1'b0,1'b0,1'b1,1'b1, 4'd6, 16'h9999, 16'h0010, 16'h8888, 16'h7777,
               3'd4, 16'd6, 16'h0010, 16'h0000, 16'h0000, 4'd0};

    rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0; rdy = 1'b0; rdy2 = 1'b0;
    inst = 16'h0000;
    idle();
    @(negedge clk);
    reset1();

    // Reset state
    chk("reset_valid", 96'(rec_valid), 96'(0));
    chk("reset_fields", rec1(), 96'(0));
    chk("reset_status", 96'({overflow, drop_count, done}), 96'(0));

    // Classification + halt sequence
    rdy = 1'b1; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].h, tbl[i].wreg, tbl[i].wdata,
            tbl[i].vpc, tbl[i].addr, tbl[i].mdata);
      tick();
      chk($sformatf("vec%0d_valid", i), 96'(rec_valid), 96'(1));
      chk($sformatf("vec%0d_rec", i), rec1(),
          mk(tbl[i].et, tbl[i].einum, tbl[i].epc, tbl[i].ea, tbl[i].eb, tbl[i].ereg));
    end
    idle();
    tick();
    chk("stats_rec", rec1(), mk(3'd5, 16'd7, 16'h0000, 16'h0007, 16'h0000, 4'd0));
    tick();
    chk("halt_done", 96'({rec_valid, done}), 96'(2'b01));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 16'hAAAA, 16'h0100, 16'h0000, 16'h0000);
      tick();
      chk("post_done_quiet", 96'({rec_valid, done}), 96'(2'b01));
    end

    // Backpressure: 10 REG into an 8-deep FIFO
    idle();
    reset1();
    rdy = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'h0100 + 16'(i), 16'(i), 16'h0000, 16'h0000);
      tick();
    end
    en = 1'b0;
    idle();
    chk("bp_overflow", 96'({overflow, drop_count}), 96'({1'b1, 8'd2}));
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_rec%0d", i), rec1(),
          mk(3'd1, 16'(i), 16'(i), 16'h0100 + 16'(i), 16'h0000, 4'd1));
      tick();
    end
    chk("bp_empty", 96'({rec_valid, overflow, done}), 96'(3'b010));

    // Halt while full
    reset1();
    rdy = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 16'h0200 + 16'(i), 16'h0020 + 16'(i),
            16'h0000, 16'h0000);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0050, 16'h0000, 16'h0000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 16'hDEAD, 16'h0060, 16'h0000, 16'h0000);
    tick();
    tick();
    chk("hf_no_drop", 96'({overflow, drop_count}), 96'(0));
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("hf_rec%0d", i), rec1(),
          mk(3'd1, 16'(i), 16'h0020 + 16'(i), 16'h0200 + 16'(i), 16'h0000, 4'd2));
      tick();
    end
    chk("hf_halt", rec1(), mk(3'd4, 16'd8, 16'h0050, 16'h0000, 16'h0000, 4'd0));
    tick();
    chk("hf_stats", rec1(), mk(3'd5, 16'd9, 16'h0000, 16'h0009, 16'h0000, 4'd0));
    tick();
    chk("hf_done", 96'({rec_valid, done, overflow}), 96'(3'b010));

    // Reset mid-stream (FIFO filled past full so overflow is set first)
    idle();
    reset1();
    rdy = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 16'h0300 + 16'(i), 16'(i), 16'h0000, 16'h0000);
      tick();
    end
    en = 1'b0;
    idle();
    chk("mid_pre", 96'({rec_valid, overflow, drop_count}), 96'({1'b1, 1'b1, 8'd1}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_post", 96'({rec_valid, overflow, drop_count}), 96'(0));
    chk("mid_fields", rec1(), 96'(0));
    rdy = 1'b1; en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 16'hCAFE, 16'h0100, 16'h0000, 16'h0000);
    tick();
    en = 1'b0;
    idle();
    chk("mid_first", rec1(), mk(3'd1, 16'd0, 16'h0100, 16'hCAFE, 16'h0000, 4'd7));

    // Timeout with NOP suppression on the second instance
    rst2 = 1'b1;
    tick();
    tick();
    rst2 = 1'b0;
    en2 = 1'b1; rdy2 = 1'b1;
    nrec = 0;
    got = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rec_valid2) begin
        nrec++;
        got = rec2();
      end
    end
    chk("to_count", 96'(nrec), 96'(1));
    chk("to_rec", got, mk(3'd6, 16'd20, 16'h0000, 16'd20, 16'h0000, 4'd0));
    chk("to_done", 96'({done2, overflow2}), 96'(2'b10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
